cpu_bus_bridge: RTL and testbench

// - Initiator side of the CPU/chip bus: turns asynchronous 68000 strobes (_as,_uds,_lds,r_w)

---
 rtl/cpu_bus_bridge.sv | 158 +++++++++++++++
 tb/tb_cpu_bus_bridge.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_bridge.sv
// Purpose: bridges asynchronous 68000 strobes to synchronous cpurd/cpuhwr/cpulwr chip-bus requests, returns _dtack/_berr.
// Latency: DS low -> _dtack low in 4 clk minimum (2 sync + 1 decode + 1 grant); DS high -> _dtack high in 3 clk.
// Backpressure: request held in REQ until cpuok grants; `define BUS_TIMEOUT_EN bounds the wait and answers with _berr.
module cpu_bus_bridge #(
    parameter int TMO_CYCLES = 255
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic        _as,
    input  logic        _uds,
    input  logic        _lds,
    input  logic        r_w,
    input  logic [15:0] cpudatain,
    output logic [15:0] cpudataout,
    output logic        _dtack,
    output logic        _berr,
    output logic        cpurd,
    output logic        cpuhwr,
    output logic        cpulwr,
    input  logic        cpuok,
    input  logic [15:0] datain,
    output logic [15:0] dataout
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;
`ifdef BUS_TIMEOUT_EN
    localparam logic [1:0] ERR  = 2'd3;
    // Counter value seen on the last tolerated ungranted REQ cycle.
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);
`endif

    // The timeout count must fit the 8-bit counter and be at least one cycle.
    if (TMO_CYCLES < 1 || TMO_CYCLES > 255) begin : g_bad_tmo
        $error("cpu_bus_bridge: TMO_CYCLES must be in 1..255");
    end

    logic [1:0] as_sync;
    logic [1:0] uds_sync;
    logic [1:0] lds_sync;
    logic [1:0] rw_sync;
    logic       s_as;
    logic       s_uds;
    logic       s_lds;
    logic       s_r_w;

    logic [1:0] state;
    logic       rd;
    logic       hi;
    logic       lo;
    logic       ds_any;
    logic       ds_none;

    // Two-flop synchronizers for the asynchronous CPU strobes; reset to the inactive level.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            as_sync  <= 2'b11;
            uds_sync <= 2'b11;
            lds_sync <= 2'b11;
            rw_sync  <= 2'b11;
        end else begin
            as_sync  <= {as_sync[0],  _as};
            uds_sync <= {uds_sync[0], _uds};
            lds_sync <= {lds_sync[0], _lds};
            rw_sync  <= {rw_sync[0],  r_w};
        end
    end

    assign s_as    = as_sync[1];
    assign s_uds   = uds_sync[1];
    assign s_lds   = lds_sync[1];
    assign s_r_w   = rw_sync[1];
    assign ds_any  = ~s_uds | ~s_lds;
    assign ds_none = s_uds & s_lds;

`ifdef BUS_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // Counts ungranted REQ cycles of the current access; cleared when a new access starts.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            tmo_cnt <= 8'd0;
        end else if (state == IDLE) begin
            tmo_cnt <= 8'd0;
        end else if (state == REQ && !s_as && !cpuok) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end
`endif

    // Bridge cycle sequencing plus the read/write data latches.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            state      <= IDLE;
            rd         <= 1'b0;
            hi         <= 1'b0;
            lo         <= 1'b0;
            cpudataout <= 16'h0000;
            dataout    <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    // AS low with both data strobes high is not yet an access.
                    if (!s_as && ds_any) begin
                        state   <= REQ;
                        rd      <= s_r_w;
                        hi      <= ~s_uds;
                        lo      <= ~s_lds;
                        dataout <= cpudatain;
                    end
                end
                REQ: begin
                    // A CPU abort beats a grant arriving in the same cycle.
                    if (s_as) begin
                        state <= IDLE;
                    end else if (cpuok) begin
                        if (rd) begin
                            cpudataout <= datain;
                        end
                        state <= ACK;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        state <= ERR;
                    end
`endif
                end
                // Leave on data strobes, not AS, so a TAS read-modify-write runs as two bridge cycles.
                ACK: begin
                    if (ds_none) begin
                        state <= IDLE;
                    end
                end
`ifdef BUS_TIMEOUT_EN
                ERR: begin
                    if (ds_none) begin
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // Requests are decoded from state so they can only be active while waiting for a grant.
    assign cpurd  = (state == REQ) &  rd;
    assign cpuhwr = (state == REQ) & ~rd & hi;
    assign cpulwr = (state == REQ) & ~rd & lo;
    assign _dtack = ~(state == ACK);
`ifdef BUS_TIMEOUT_EN
    assign _berr  = ~(state == ERR);
`else
    assign _berr  = 1'b1;
`endif

endmodule

// File: tb/tb_cpu_bus_bridge.sv
`timescale 1ns/1ps
module tb_cpu_bus_bridge;

    localparam int TMO = 4;
`ifdef BUS_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        _reset, _as, _uds, _lds, r_w, cpuok;
    logic [15:0] cpudatain, datain, cpudataout, dataout;
    logic        _dtack, _berr, cpurd, cpuhwr, cpulwr;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit rnd_mode = 1'b0;
    int ok_pct = 100;
    int n, nrd, nhw, nlw, nlow, abort_at;
    logic [1:0] ds;

    cpu_bus_bridge #(.TMO_CYCLES(TMO)) dut (
        .clk(clk), ._reset(_reset), ._as(_as), ._uds(_uds), ._lds(_lds), .r_w(r_w),
        .cpudatain(cpudatain), .cpudataout(cpudataout), ._dtack(_dtack), ._berr(_berr),
        .cpurd(cpurd), .cpuhwr(cpuhwr), .cpulwr(cpulwr), .cpuok(cpuok),
        .datain(datain), .dataout(dataout)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The bridge sees each pin as it was two clock edges earlier.
    localparam int M_IDLE = 0, M_BUSY = 1, M_DONE = 2, M_FAIL = 3;
    int          m_ph;
    bit          m_rd, m_hi, m_lo;
    logic [15:0] m_rdat, m_wdat;
    int          m_wait;
    logic [3:0]  h0, h1, s;   // {as, uds, lds, r_w}

    always @(posedge clk) begin
        if (!_reset) begin
            h0 = 4'hF; h1 = 4'hF;
            m_ph = M_IDLE; m_rd = 0; m_hi = 0; m_lo = 0;
            m_rdat = 16'h0; m_wdat = 16'h0; m_wait = 0;
        end else begin
            s = h1;
            if (m_ph == M_IDLE) begin
                if (!s[3] && (!s[2] || !s[1])) begin
                    m_ph = M_BUSY; m_rd = s[0]; m_hi = !s[2]; m_lo = !s[1];
                    m_wdat = cpudatain; m_wait = 0;
                end
            end else if (m_ph == M_BUSY) begin
                if (s[3]) m_ph = M_IDLE;
                else if (cpuok) begin
                    if (m_rd) m_rdat = datain;
                    m_ph = M_DONE;
                end else begin
                    m_wait++;
                    if (TMO_ON && m_wait == TMO) m_ph = M_FAIL;
                end
            end else if (s[2] && s[1]) begin
                m_ph = M_IDLE;
            end
            h1 = h0;
            h0 = {_as, _uds, _lds, r_w};
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk1("cpurd",  cpurd,  m_ph == M_BUSY && m_rd);
            chk1("cpuhwr", cpuhwr, m_ph == M_BUSY && !m_rd && m_hi);
            chk1("cpulwr", cpulwr, m_ph == M_BUSY && !m_rd && m_lo);
            chk1("_dtack", _dtack, m_ph != M_DONE);
            chk1("_berr",  _berr,  m_ph != M_FAIL);
            chk16("cpudataout", cpudataout, m_rdat);
            chk16("dataout",    dataout,    m_wdat);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        if (rnd_mode) begin
            cpuok  = ($urandom_range(0, 99) < ok_pct);
            datain = 16'($urandom);
        end
    endtask

    task automatic release_bus();
        _as = 1'b1; _uds = 1'b1; _lds = 1'b1;
    endtask

    initial begin
        _reset = 1'b0; _as = 1'b1; _uds = 1'b1; _lds = 1'b1; r_w = 1'b1;
        cpuok = 1'b0; cpudatain = 16'h0; datain = 16'h0;
        @(posedge clk); #2;
        chk_en = 1'b1;
        tick();
        chk1("rst_dtack", _dtack, 1'b1);
        chk1("rst_berr", _berr, 1'b1);
        chk1("rst_strobes", cpurd | cpuhwr | cpulwr, 1'b0);
        chk16("rst_cpudataout", cpudataout, 16'h0000);
        chk16("rst_dataout", dataout, 16'h0000);
        _reset = 1'b1;
        tick(); tick();

        // Word read, granted immediately.
        cpuok = 1'b1; datain = 16'hA55A; r_w = 1'b1;
        _as = 1'b0; _uds = 1'b0; _lds = 1'b0;
        n = 0; nrd = 0; nhw = 0;
        while (n < 20) begin
            tick(); n++;
            if (cpurd) nrd++;
            if (cpuhwr | cpulwr) nhw++;
            if (!_dtack) break;
        end
        chkn("read_dtack_latency", n, 4);
        chkn("read_cpurd_pulses", nrd, 1);
        chkn("read_write_pulses", nhw, 0);
        chk16("read_data", cpudataout, 16'hA55A);
        release_bus();
        n = 0;
        while (n < 10) begin tick(); n++; if (_dtack) break; end
        chkn("read_dtack_release", n, 3);
        tick(); tick();

        // High-byte write.
        r_w = 1'b0; cpudatain = 16'h12FF;
        _as = 1'b0; _uds = 1'b0; _lds = 1'b1;
        n = 0; nrd = 0; nhw = 0; nlw = 0;
        while (n < 20) begin
            tick(); n++;
            if (cpurd) nrd++;
            if (cpuhwr) nhw++;
            if (cpulwr) nlw++;
            if (!_dtack) break;
        end
        chkn("wrhi_cpuhwr_pulses", nhw, 1);
        chkn("wrhi_cpulwr_pulses", nlw, 0);
        chkn("wrhi_cpurd_pulses", nrd, 0);
        chk16("wrhi_dataout", dataout, 16'h12FF);
        release_bus();
        repeat (5) tick();

`ifndef BUS_TIMEOUT_EN
        // Ten wait states, then a grant.
        cpuok = 1'b0; r_w = 1'b1; datain = 16'h0BEE;
        _as = 1'b0; _uds = 1'b0; _lds = 1'b0;
        n = 0;
        while (n < 10) begin tick(); n++; if (cpurd) break; end
        chk1("wait_req_seen", cpurd, 1'b1);
        nrd = 1; nlow = 0;
        repeat (10) begin
            tick();
            if (cpurd) nrd++;
            if (!_dtack) nlow++;
        end
        cpuok = 1'b1;
        tick();
        chkn("wait_cpurd_cycles", nrd, 11);
        chkn("wait_dtack_early", nlow, 0);
        chk1("wait_dtack_after_grant", _dtack, 1'b0);
        chk16("wait_read_data", cpudataout, 16'h0BEE);
        release_bus();
        repeat (5) tick();
`endif

        // Abort while waiting for a grant.
        cpuok = 1'b0; r_w = 1'b1;
        _as = 1'b0; _uds = 1'b0; _lds = 1'b0;
        n = 0;
        while (n < 10) begin tick(); n++; if (cpurd) break; end
        release_bus();
        n = 0; nlow = 0;
        while (n < 10) begin
            tick(); n++;
            if (!_dtack) nlow++;
            if (!(cpurd | cpuhwr | cpulwr)) break;
        end
        chkn("abort_strobe_drop", n, 3);
        repeat (4) begin tick(); if (!_dtack) nlow++; end
        chkn("abort_no_dtack", nlow, 0);

        // Grant never comes.
        cpuok = 1'b0; r_w = 1'b1;
        _as = 1'b0; _uds = 1'b0; _lds = 1'b0;
        n = 0;
        while (n < 10) begin tick(); n++; if (cpurd) break; end
`ifdef BUS_TIMEOUT_EN
        n = 0;
        while (n < 10) begin tick(); n++; if (!_berr) break; end
        chkn("tmo_berr_latency", n, 4);
        chk1("tmo_strobes", cpurd | cpuhwr | cpulwr, 1'b0);
        chk1("tmo_dtack", _dtack, 1'b1);
        release_bus();
        n = 0;
        while (n < 10) begin tick(); n++; if (_berr) break; end
        chkn("tmo_berr_release", n, 3);
`else
        repeat (8) tick();
        chk1("notmo_berr", _berr, 1'b1);
        chk1("notmo_req_held", cpurd, 1'b1);
        release_bus();
        repeat (4) tick();
        chk1("notmo_req_dropped", cpurd, 1'b0);
`endif
        repeat (3) tick();

        // Reset during ACK.
        cpuok = 1'b1; datain = 16'h1234; r_w = 1'b1;
        _as = 1'b0; _uds = 1'b0; _lds = 1'b0;
        n = 0;
        while (n < 20) begin tick(); n++; if (!_dtack) break; end
        chk16("mid_read_data", cpudataout, 16'h1234);
        _reset = 1'b0;
        tick();
        chk1("mid_rst_dtack", _dtack, 1'b1);
        chk1("mid_rst_strobes", cpurd | cpuhwr | cpulwr, 1'b0);
        chk16("mid_rst_cpudataout", cpudataout, 16'h0000);
        chk16("mid_rst_dataout", dataout, 16'h0000);
        _reset = 1'b1;
        release_bus();
        repeat (4) tick();

        // Randomized CPU cycles, including aborts, idle DS patterns and TAS-style pairs.
        rnd_mode = 1'b1;
        for (int t = 0; t < 250; t++) begin
            ok_pct    = $urandom_range(10, 100);
            r_w       = 1'($urandom_range(0, 1));
            cpudatain = 16'($urandom);
            ds        = 2'($urandom_range(0, 3));
            abort_at  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 8) : 1000;
            _as = 1'b0; _uds = ds[1]; _lds = ds[0];
            n = 0;
            while (n < 30) begin
                tick(); n++;
                if (!_dtack || !_berr || n == abort_at) break;
            end
            if (!_dtack && $urandom_range(0, 4) == 0) begin
                _uds = 1'b1; _lds = 1'b1;
                repeat (4) tick();
                r_w = 1'b0; cpudatain = 16'($urandom);
                _uds = 1'b0; _lds = 1'b0;
                n = 0;
                while (n < 30) begin tick(); n++; if (!_dtack || !_berr) break; end
            end
            release_bus();
            repeat ($urandom_range(3, 6)) tick();
        end
        rnd_mode = 1'b0;
        repeat (3) tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
